serial_sum_collect: RTL and testbench
=====================================

SERIAL_SUM_COLLECT -- requirements
Module: serial_sum_collect

Interface
REQ-001 Parameter WIDTH, default 4, is the operand/result width in bits; legal range 2..16.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting it low forces the reset state immediately, independent of clk.
REQ-004 start  input  1  high marks the cycle carrying bit 0 (the LSB) of a new operand pair.
REQ-005 a_bit  input  1  serial operand A, LSB first, one bit per cycle.
REQ-006 b_bit  input  1  serial operand B, LSB first, one bit per cycle.
REQ-007 c_in  input  1  initial carry, sampled only in the start cycle.
REQ-008 sum  output  WIDTH  registered result of the last completed addition.
REQ-009 cout  output  1  registered final carry of the last completed addition.
REQ-010 done  output  1  single-cycle pulse; sum/cout updated in the same cycle.
REQ-011 busy  output  1  high while an operation is collecting bits.

Function
REQ-012 The block SHALL implement a one-bit full adder with a carry flip-flop: s = a_bit^b_bit^carry, carry_next = majority(a_bit, b_bit, carry).
REQ-013 The state machine SHALL have three states: IDLE, ADD, DONE.
REQ-014 IDLE: on start=1, the block SHALL consume bit 0 using c_in as the carry, set bit counter to 1 and go to ADD; start=0 stays in IDLE and consumes nothing.
REQ-015 ADD: the block SHALL consume one bit pair per cycle using the stored carry, shifting s into a WIDTH-bit shift register (insert at MSB, shift right), and increment the counter.
REQ-016 When the WIDTH-th bit is consumed, the block SHALL go to DONE and copy the shift register to sum and the final carry to cout on that same edge.
REQ-017 done SHALL be high exactly during the DONE cycle, one cycle after the last bit is presented; total latency from start cycle to done is WIDTH cycles.
REQ-018 busy SHALL be high in ADD and low in IDLE and DONE.
REQ-019 start asserted while in ADD SHALL be ignored; the current operation continues unaffected.
REQ-020 start asserted in DONE SHALL be accepted exactly as in IDLE (back-to-back operation without a gap).
REQ-021 sum and cout SHALL hold their values between completions; partial results are never visible on sum.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL not wrap during an operation.

Reset
REQ-023 On reset low: state=IDLE, counter=0, carry=0, shift register=0, sum=0, cout=0, done=0, busy=0.
REQ-024 Reset asserted mid-operation SHALL abort it; the partial result is discarded and sum/cout revert to 0.
REQ-025 After reset release, the first rising edge with start=1 SHALL begin a new operation.

Structure
REQ-026 State encodings (IDLE, ADD, DONE) and the default WIDTH constant SHALL live in a shared package used by both this block and the serializer stage.
REQ-027 The full-adder cell SHALL be a separate sub-module named full_adder_bit; everything else stays in serial_sum_collect.

Verification
REQ-028 5+3, c_in=0: a_bit=1,0,1,0, b_bit=1,1,0,0 -> done in cycle 4, sum=4'b1000, cout=0.
REQ-029 15+1, c_in=0 -> sum=0, cout=1; 7+8, c_in=1 -> sum=0, cout=1.
REQ-030 start pulsed again at cycle 2 of an operation -> ignored; result equals the undisturbed 5+3 case.
REQ-031 Back-to-back: second start in the DONE cycle with 2+2 -> two done pulses 4 cycles apart, sums 8 then 4.
REQ-032 Reset low at cycle 2 of 9+6 -> all outputs 0 immediately, no done pulse; next operation 1+1 -> sum=2.
REQ-033 Random regression, WIDTH=4 and WIDTH=8, 1000 operations -> {cout,sum} == A+B+c_in every time.

Source files
------------

// File: rtl/serial_sum_collect_pkg.sv
// Shared definitions for the serial adder/collector and the serializer stage.
package serial_sum_collect_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sum_collect_if.sv
// Serial operand stream in, parallel result and status out.
interface serial_sum_collect_if
    import serial_sum_collect_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic             a_bit;
    logic             b_bit;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             done;
    logic             busy;

    modport master (
        output start, a_bit, b_bit, c_in,
        input  sum, cout, done, busy
    );

    modport slave (
        input  start, a_bit, b_bit, c_in,
        output sum, cout, done, busy
    );

endinterface

// File: rtl/full_adder_bit.sv
// One-bit full adder cell used by the serial adder.
module full_adder_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum_c,
    output logic o_carry_c
);

    // Sum and majority carry.
    assign o_sum_c   = i_a ^ i_b ^ i_c;
    assign o_carry_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_sum_collect.sv
// Bit-serial adder: collects WIDTH LSB-first bit pairs and publishes the sum
// and final carry in one registered update, pulsing done for one cycle.
module serial_sum_collect
    import serial_sum_collect_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
)(
    input  logic              clk,
    input  logic              reset,
    serial_sum_collect_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_done;
    logic               r_busy;

    logic               w_carry_in;
    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_shreg_next;
    logic               w_shreg_lsb_unused;

    // The start cycle takes its carry from c_in; later bits use the stored carry.
    assign w_carry_in = (r_state == ST_ADD) ? r_carry : bus.c_in;

    full_adder_bit u_fa (
        .i_a       (bus.a_bit),
        .i_b       (bus.b_bit),
        .i_c       (w_carry_in),
        .o_sum_c   (w_s),
        .o_carry_c (w_c)
    );

    // New sum bit enters at the MSB; the old LSB falls off and is never needed.
    assign w_shreg_next       = {w_s, r_shreg[WIDTH-1:1]};
    assign w_shreg_lsb_unused = r_shreg[0];

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_shreg <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_carry <= w_c;
                        r_shreg <= w_shreg_next;
                        r_cnt   <= CNT_W'(1);
                        r_state <= ST_ADD;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_ADD: begin
                    r_carry <= w_c;
                    r_shreg <= w_shreg_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Last bit: publish result on the same edge it completes.
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= ST_DONE;
                        r_sum   <= w_shreg_next;
                        r_cout  <= w_c;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.done = r_done;
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_serial_sum_collect.sv
// Directed and randomized checks of serial_sum_collect at WIDTH=4 and WIDTH=8.
module tb_serial_sum_collect;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_sum_collect_if #(.WIDTH(4)) bus4 ();
    serial_sum_collect_if #(.WIDTH(8)) bus8 ();

    serial_sum_collect #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    serial_sum_collect #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));

    task automatic idle4();
        bus4.start = 1'b0; bus4.a_bit = 1'b0; bus4.b_bit = 1'b0; bus4.c_in = 1'b0;
    endtask

    task automatic idle8();
        bus8.start = 1'b0; bus8.a_bit = 1'b0; bus8.b_bit = 1'b0; bus8.c_in = 1'b0;
    endtask

    // Drives one 4-bit operation starting at the current negedge; st gives start per cycle.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic [3:0] st);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            bus4.start = st[k]; bus4.a_bit = a[k]; bus4.b_bit = b[k]; bus4.c_in = cin;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            bus8.start = (k == 0); bus8.a_bit = a[k]; bus8.b_bit = b[k]; bus8.c_in = cin;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle4();
        idle8();
        #12;
        n_checks++; if (bus4.sum !== 4'h0) begin n_fail++; $display("FAIL reset_sum4: got %0h want 0", bus4.sum); end
        n_checks++; if (bus4.cout !== 1'b0 || bus4.done !== 1'b0 || bus4.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags4: cout=%b done=%b busy=%b want 000", bus4.cout, bus4.done, bus4.busy); end
        n_checks++; if (bus8.sum !== 8'h00 || bus8.cout !== 1'b0 || bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_all8: sum=%0h cout=%b done=%b busy=%b want 0", bus8.sum, bus8.cout, bus8.done, bus8.busy); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: busy=%b done=%b want 00", bus4.busy, bus4.done); end
    endtask

    task automatic test_basic();
        logic [3:0] a = 4'd5;
        logic [3:0] b = 4'd3;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                n_checks++; if (bus4.busy !== 1'b1 || bus4.done !== 1'b0 || bus4.sum !== 4'h0) begin
                    n_fail++; $display("FAIL basic_mid%0d: busy=%b done=%b sum=%0h want 1 0 0", k, bus4.busy, bus4.done, bus4.sum); end
            end
            bus4.start = (k == 0); bus4.a_bit = a[k]; bus4.b_bit = b[k]; bus4.c_in = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (bus4.done !== 1'b1 || bus4.busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_done: done=%b busy=%b want 1 0", bus4.done, bus4.busy); end
        n_checks++; if ({bus4.cout, bus4.sum} !== 5'b01000) begin
            n_fail++; $display("FAIL basic_result: got cout=%b sum=%b want 0 1000", bus4.cout, bus4.sum); end
        idle4();
        @(negedge clk);
        n_checks++; if (bus4.done !== 1'b0 || bus4.sum !== 4'h8) begin
            n_fail++; $display("FAIL basic_hold: done=%b sum=%0h want 0 8", bus4.done, bus4.sum); end
    endtask

    task automatic test_carry();
        run4(4'd15, 4'd1, 1'b0, 4'b0001);
        @(negedge clk);
        n_checks++; if (bus4.done !== 1'b1 || {bus4.cout, bus4.sum} !== 5'b10000) begin
            n_fail++; $display("FAIL carry_15p1: done=%b cout=%b sum=%0h want 1 1 0", bus4.done, bus4.cout, bus4.sum); end
        idle4();
        @(negedge clk);
        run4(4'd7, 4'd8, 1'b1, 4'b0001);
        @(negedge clk);
        n_checks++; if (bus4.done !== 1'b1 || {bus4.cout, bus4.sum} !== 5'b10000) begin
            n_fail++; $display("FAIL carry_7p8c1: done=%b cout=%b sum=%0h want 1 1 0", bus4.done, bus4.cout, bus4.sum); end
        run4(4'd15, 4'd15, 1'b1, 4'b0001);
        @(negedge clk);
        n_checks++; if (bus4.done !== 1'b1 || {bus4.cout, bus4.sum} !== 5'b11111) begin
            n_fail++; $display("FAIL carry_max: done=%b cout=%b sum=%0h want 1 1 f", bus4.done, bus4.cout, bus4.sum); end
        idle4();
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        run4(4'd5, 4'd3, 1'b0, 4'b0111);
        @(negedge clk);
        n_checks++; if (bus4.done !== 1'b1 || {bus4.cout, bus4.sum} !== 5'b01000) begin
            n_fail++; $display("FAIL start_ignored: done=%b cout=%b sum=%0h want 1 0 8", bus4.done, bus4.cout, bus4.sum); end
        idle4();
        @(negedge clk);
        n_checks++; if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) begin
            n_fail++; $display("FAIL start_ignored_after: done=%b busy=%b want 0 0", bus4.done, bus4.busy); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a = 4'd2;
        logic [3:0] b = 4'd2;
        run4(4'd5, 4'd3, 1'b0, 4'b0001);
        @(negedge clk);
        n_checks++; if (bus4.done !== 1'b1 || bus4.sum !== 4'h8) begin
            n_fail++; $display("FAIL b2b_first: done=%b sum=%0h want 1 8", bus4.done, bus4.sum); end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                n_checks++; if (bus4.done !== 1'b0 || bus4.sum !== 4'h8) begin
                    n_fail++; $display("FAIL b2b_gap%0d: done=%b sum=%0h want 0 8", k, bus4.done, bus4.sum); end
            end
            bus4.start = (k == 0); bus4.a_bit = a[k]; bus4.b_bit = b[k]; bus4.c_in = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (bus4.done !== 1'b1 || {bus4.cout, bus4.sum} !== 5'b00100) begin
            n_fail++; $display("FAIL b2b_second: done=%b cout=%b sum=%0h want 1 0 4", bus4.done, bus4.cout, bus4.sum); end
        idle4();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic seen_done = 1'b0;
        run4(4'd9, 4'd6, 1'b0, 4'b0001);
        // run4 returns after presenting bit 3; abort instead during bit 1 via a fresh op
        @(negedge clk);
        idle4();
        @(negedge clk);
        bus4.start = 1'b1; bus4.a_bit = 1'b1; bus4.b_bit = 1'b0; bus4.c_in = 1'b0;
        @(negedge clk);
        bus4.start = 1'b0; bus4.a_bit = 1'b0; bus4.b_bit = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (bus4.sum !== 4'h0 || bus4.cout !== 1'b0 || bus4.done !== 1'b0 || bus4.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: sum=%0h cout=%b done=%b busy=%b want 0", bus4.sum, bus4.cout, bus4.done, bus4.busy); end
        @(negedge clk);
        reset = 1'b1;
        idle4();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus4.done !== 1'b0 || bus4.sum !== 4'h0) seen_done = 1'b1;
        end
        n_checks++; if (seen_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_quiet: got activity=%b want 0", seen_done); end
        run4(4'd1, 4'd1, 1'b0, 4'b0001);
        @(negedge clk);
        n_checks++; if (bus4.done !== 1'b1 || {bus4.cout, bus4.sum} !== 5'b00010) begin
            n_fail++; $display("FAIL reset_mid_next: done=%b cout=%b sum=%0h want 1 0 2", bus4.done, bus4.cout, bus4.sum); end
        idle4();
        @(negedge clk);
    endtask

    task automatic test_width8();
        logic [7:0] ta [4] = '{8'd170, 8'd0, 8'd200, 8'd255};
        logic [7:0] tb [4] = '{8'd85,  8'd0, 8'd100, 8'd0};
        logic       tc [4] = '{1'b0,   1'b0, 1'b1,   1'b1};
        logic [8:0] te [4] = '{9'd255, 9'd0, 9'd301, 9'd256};
        for (int i = 0; i < 4; i++) begin
            run8(ta[i], tb[i], tc[i]);
            @(negedge clk);
            n_checks++; if (bus8.done !== 1'b1 || {bus8.cout, bus8.sum} !== te[i]) begin
                n_fail++; $display("FAIL w8_case%0d: done=%b got %0d want %0d", i, bus8.done, {bus8.cout, bus8.sum}, te[i]); end
        end
        idle8();
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] a4, b4;
        logic [7:0] a8, b8;
        logic       c;
        logic [4:0] e4;
        logic [8:0] e8;
        for (int i = 0; i < 1000; i++) begin
            a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15)); c = 1'($urandom_range(0, 1));
            e4 = 5'(a4) + 5'(b4) + 5'(c);
            run4(a4, b4, c, 4'b0001);
            @(negedge clk);
            n_checks++; if (bus4.done !== 1'b1 || {bus4.cout, bus4.sum} !== e4) begin
                n_fail++; $display("FAIL rand4_%0d: %0d+%0d+%0d done=%b got %0d want %0d", i, a4, b4, c, bus4.done, {bus4.cout, bus4.sum}, e4); end
        end
        idle4();
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255)); c = 1'($urandom_range(0, 1));
            e8 = 9'(a8) + 9'(b8) + 9'(c);
            run8(a8, b8, c);
            @(negedge clk);
            n_checks++; if (bus8.done !== 1'b1 || {bus8.cout, bus8.sum} !== e8) begin
                n_fail++; $display("FAIL rand8_%0d: %0d+%0d+%0d done=%b got %0d want %0d", i, a8, b8, c, bus8.done, {bus8.cout, bus8.sum}, e8); end
        end
        idle8();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_width8();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
